// File: rtl/fifo_mem_responder.sv
// Command responder between the fifo-cache port and the DDR3 native port.
// Writes go straight out; read beats return through a credit-guarded FIFO.
module fifo_mem_responder #(
    parameter int RSP_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         io_fifo_cmd_valid,
    output logic         io_fifo_cmd_ready,
    input  logic         io_fifo_cmd_type,
    input  logic [26:0]  io_fifo_cmd_addr,
    input  logic [5:0]   io_fifo_cmd_burst_cnt,
    input  logic [127:0] io_fifo_cmd_wt_data,
    input  logic [15:0]  io_fifo_cmd_wt_mask,
    output logic         io_fifo_rsp_valid,
    input  logic         io_fifo_rsp_ready,
    output logic [127:0] io_fifo_rsp_data,
    input  logic         io_mem_init_calib_complete,
    input  logic         io_mem_cmd_ready,
    output logic         io_mem_cmd_en,
    output logic [2:0]   io_mem_cmd,
    output logic [26:0]  io_mem_addr,
    input  logic         io_mem_wr_data_rdy,
    output logic         io_mem_wr_data_en,
    output logic         io_mem_wr_data_end,
    output logic [127:0] io_mem_wr_data,
    output logic [15:0]  io_mem_wr_data_mask,
    input  logic         io_mem_rd_data_valid,
    input  logic [127:0] io_mem_rd_data,
    input  logic         io_mem_rd_data_end
);
    localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(RSP_DEPTH);
    localparam logic [CW:0] LIMIT = (CW + 1)'(RSP_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DRAIN
    } state_t;

    state_t          state;
    logic            calib_q;
    logic            type_q;
    logic [26:0]     addr_q;
    logic [127:0]    data_q;
    logic [15:0]     mask_q;
    logic [6:0]      beats_q;
    logic [5:0]      issued;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [127:0]    rsp_mem [RSP_DEPTH];

    logic credit_ok;
    logic wr_fire;
    logic rd_fire;
    logic last_beat;
    logic push;
    logic pop;

    wire unused_ok = &{1'b0, io_mem_rd_data_end, io_fifo_cmd_addr[3:0]};

    // Beats already in the FIFO plus beats still in flight must fit.
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < LIMIT;
    assign wr_fire = (state == WR) && io_mem_cmd_ready && io_mem_wr_data_rdy;
    assign rd_fire = (state == RD) && io_mem_cmd_ready && credit_ok;
    assign last_beat = (({1'b0, issued} + 7'd1) == beats_q);
    assign push = io_mem_rd_data_valid && (outstanding != '0)
                  && (count != FULL);
    assign pop = (count != '0) && io_fifo_rsp_ready;

    assign io_fifo_cmd_ready = (state == IDLE) && calib_q;
    assign io_mem_cmd_en = wr_fire || rd_fire;
    assign io_mem_cmd = {2'b00, type_q};
    assign io_mem_addr = addr_q + {17'd0, issued, 4'd0};
    assign io_mem_wr_data_en = wr_fire;
    assign io_mem_wr_data_end = wr_fire;
    assign io_mem_wr_data = data_q;
    assign io_mem_wr_data_mask = mask_q;
    assign io_fifo_rsp_valid = (count != '0);
    assign io_fifo_rsp_data = io_fifo_rsp_valid ? rsp_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            calib_q <= 1'b0;
            type_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= 16'hFFFF;
            beats_q <= '0;
            issued  <= '0;
        end else begin
            calib_q <= io_mem_init_calib_complete;
            unique case (state)
                IDLE: begin
                    if (io_fifo_cmd_valid && io_fifo_cmd_ready) begin
                        type_q  <= io_fifo_cmd_type;
                        addr_q  <= {io_fifo_cmd_addr[26:4], 4'b0};
                        data_q  <= io_fifo_cmd_wt_data;
                        mask_q  <= io_fifo_cmd_wt_mask;
                        beats_q <= {1'b0, io_fifo_cmd_burst_cnt} + 7'd1;
                        issued  <= '0;
                        state   <= io_fifo_cmd_type ? RD : WR;
                    end
                end
                WR: begin
                    if (wr_fire) state <= IDLE;
                end
                RD: begin
                    if (rd_fire) begin
                        issued <= issued + 6'd1;
                        if (last_beat) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(rd_fire) - CW'(push);
            count       <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) rsp_mem[wr_ptr] <= io_mem_rd_data;
    end

endmodule

// File: tb/tb_fifo_mem_responder.sv
// Bench for fifo_mem_responder: directed table, corner sequences and
// randomized traffic against a transaction-level model.
module tb_fifo_mem_responder;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         io_fifo_cmd_valid = 1'b0;
    logic         io_fifo_cmd_ready;
    logic         io_fifo_cmd_type = 1'b0;
    logic [26:0]  io_fifo_cmd_addr = '0;
    logic [5:0]   io_fifo_cmd_burst_cnt = '0;
    logic [127:0] io_fifo_cmd_wt_data = '0;
    logic [15:0]  io_fifo_cmd_wt_mask = '0;
    logic         io_fifo_rsp_valid;
    logic         io_fifo_rsp_ready = 1'b0;
    logic [127:0] io_fifo_rsp_data;
    logic         io_mem_init_calib_complete = 1'b1;
    logic         io_mem_cmd_ready = 1'b0;
    logic         io_mem_cmd_en;
    logic [2:0]   io_mem_cmd;
    logic [26:0]  io_mem_addr;
    logic         io_mem_wr_data_rdy = 1'b0;
    logic         io_mem_wr_data_en;
    logic         io_mem_wr_data_end;
    logic [127:0] io_mem_wr_data;
    logic [15:0]  io_mem_wr_data_mask;
    logic         io_mem_rd_data_valid = 1'b0;
    logic [127:0] io_mem_rd_data = '0;
    logic         io_mem_rd_data_end = 1'b0;

    fifo_mem_responder #(.RSP_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .io_fifo_cmd_valid(io_fifo_cmd_valid),
        .io_fifo_cmd_ready(io_fifo_cmd_ready),
        .io_fifo_cmd_type(io_fifo_cmd_type),
        .io_fifo_cmd_addr(io_fifo_cmd_addr),
        .io_fifo_cmd_burst_cnt(io_fifo_cmd_burst_cnt),
        .io_fifo_cmd_wt_data(io_fifo_cmd_wt_data),
        .io_fifo_cmd_wt_mask(io_fifo_cmd_wt_mask),
        .io_fifo_rsp_valid(io_fifo_rsp_valid),
        .io_fifo_rsp_ready(io_fifo_rsp_ready),
        .io_fifo_rsp_data(io_fifo_rsp_data),
        .io_mem_init_calib_complete(io_mem_init_calib_complete),
        .io_mem_cmd_ready(io_mem_cmd_ready),
        .io_mem_cmd_en(io_mem_cmd_en),
        .io_mem_cmd(io_mem_cmd),
        .io_mem_addr(io_mem_addr),
        .io_mem_wr_data_rdy(io_mem_wr_data_rdy),
        .io_mem_wr_data_en(io_mem_wr_data_en),
        .io_mem_wr_data_end(io_mem_wr_data_end),
        .io_mem_wr_data(io_mem_wr_data),
        .io_mem_wr_data_mask(io_mem_wr_data_mask),
        .io_mem_rd_data_valid(io_mem_rd_data_valid),
        .io_mem_rd_data(io_mem_rd_data),
        .io_mem_rd_data_end(io_mem_rd_data_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   cmd;
        logic [26:0]  addr;
        logic [127:0] data;
        logic [15:0]  mask;
    } mcmd_t;

    typedef struct {
        int           due;
        logic [127:0] data;
    } beat_t;

    typedef struct {
        logic         typ;
        logic [26:0]  addr;
        logic [5:0]   burst;
        logic [127:0] data;
        logic [15:0]  mask;
        int           lat;
        int           exp_cmds;
        logic [26:0]  exp_first;
        logic [26:0]  exp_last;
        int           exp_rsps;
        int           exp_span;
    } vec_t;

    int vec = 0;
    int err = 0;
    int cyc = 0;
    int lat = 2;
    int p_cmd = 100;
    int p_wr = 100;
    int p_rsp = 100;

    mcmd_t        exp_cmd[$];
    logic [127:0] exp_rsp[$];
    beat_t        mq[$];
    mcmd_t        mon_e;

    int          t_n = 0;
    logic [26:0] t_first = '0;
    logic [26:0] t_last = '0;
    int          t_first_cyc = 0;
    int          t_last_cyc = 0;
    int          n_rsp = 0;
    int          n_rsp_any = 0;
    int          issued = 0;
    int          popped = 0;
    bit          hold_prev = 1'b0;
    logic [127:0] hold_data = '0;

    function automatic logic [127:0] memf(input logic [26:0] a);
        return {5'h11, a, 5'h0A, ~a, 5'h13, a ^ 27'h2AAAAAA, 5'h0C, a + 27'd7};
    endfunction

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        vec++;
        err++;
        $display("FAIL %s: bound expired before the event", name);
    endtask

    task automatic unexpected(input string name);
        vec++;
        err++;
        $display("FAIL %s: got an event expected none", name);
    endtask

    // Reference model: what the memory side and response side must see.
    task automatic model_accept();
        logic [26:0] base;
        logic [26:0] a;
        base = {io_fifo_cmd_addr[26:4], 4'b0};
        if (!io_fifo_cmd_type) begin
            exp_cmd.push_back(mcmd_t'{3'b000, base, io_fifo_cmd_wt_data,
                                      io_fifo_cmd_wt_mask});
        end else begin
            for (int i = 0; i <= int'(io_fifo_cmd_burst_cnt); i++) begin
                a = base + 27'(i * 16);
                exp_cmd.push_back(mcmd_t'{3'b001, a, '0, '0});
                exp_rsp.push_back(memf(a));
            end
        end
    endtask

    // Memory controller and consumer stimulus.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        io_mem_cmd_ready = ($urandom_range(99) < p_cmd);
        io_mem_wr_data_rdy = ($urandom_range(99) < p_wr);
        io_fifo_rsp_ready = ($urandom_range(99) < p_rsp);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            io_mem_rd_data_valid = 1'b1;
            io_mem_rd_data = mq[0].data;
            mq.pop_front();
        end else begin
            io_mem_rd_data_valid = 1'b0;
            io_mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
        end
        io_mem_rd_data_end = io_mem_rd_data_valid;
    end

    always begin
        @(negedge clk);
        if (!rst) begin
            if (io_fifo_cmd_valid && io_fifo_cmd_ready) model_accept();
            if (io_mem_cmd_en || io_mem_wr_data_en || io_mem_wr_data_end)
                chk("wr_strobes", {io_mem_wr_data_en, io_mem_wr_data_end},
                    {2{io_mem_cmd_en && io_mem_cmd == 3'b000}});
            if (io_mem_cmd_en) begin
                if (exp_cmd.size() == 0) begin
                    unexpected("mem_cmd_en");
                end else begin
                    mon_e = exp_cmd.pop_front();
                    chk("mem_cmd", io_mem_cmd, mon_e.cmd);
                    chk("mem_addr", io_mem_addr, mon_e.addr);
                    if (mon_e.cmd == 3'b000) begin
                        chk("wr_data", io_mem_wr_data, mon_e.data);
                        chk("wr_mask", io_mem_wr_data_mask, mon_e.mask);
                    end
                end
                if (t_n == 0) begin
                    t_first = io_mem_addr;
                    t_first_cyc = cyc;
                end
                t_last = io_mem_addr;
                t_last_cyc = cyc;
                t_n++;
                if (io_mem_cmd == 3'b001) begin
                    mq.push_back(beat_t'{cyc + lat, memf(io_mem_addr)});
                    issued++;
                    chk("credit", (issued - popped) <= DEPTH, 1'b1);
                end
            end
            if (hold_prev)
                chk("rsp_hold", {io_fifo_rsp_valid, io_fifo_rsp_data},
                    {1'b1, hold_data});
            if (io_fifo_rsp_valid) n_rsp_any++;
            if (io_fifo_rsp_valid && io_fifo_rsp_ready) begin
                popped++;
                n_rsp++;
                if (exp_rsp.size() == 0) unexpected("rsp_beat");
                else chk("rsp_data", io_fifo_rsp_data, exp_rsp.pop_front());
            end
            hold_prev = io_fifo_rsp_valid && !io_fifo_rsp_ready;
            hold_data = io_fifo_rsp_data;
        end
    end

    task automatic send(input logic typ, input logic [26:0] addr,
                        input logic [5:0] bc, input logic [127:0] d,
                        input logic [15:0] m);
        bit ok = 1'b0;
        @(posedge clk);
        #2;
        io_fifo_cmd_valid = 1'b1;
        io_fifo_cmd_type = typ;
        io_fifo_cmd_addr = addr;
        io_fifo_cmd_burst_cnt = bc;
        io_fifo_cmd_wt_data = d;
        io_fifo_cmd_wt_mask = m;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = io_fifo_cmd_ready;
        end
        @(posedge clk);
        #2;
        io_fifo_cmd_valid = 1'b0;
        if (!ok) expired("send");
    endtask

    task automatic wait_idle(input int maxc);
        bit ok = 1'b0;
        for (int k = 0; k < maxc && !ok; k++) begin
            @(negedge clk);
            ok = io_fifo_cmd_ready;
        end
        #1;
        if (!ok) expired("wait_idle");
    endtask

    task automatic wait_rsp_empty(input int maxc);
        bit ok = (exp_rsp.size() == 0);
        for (int k = 0; k < maxc && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = (exp_rsp.size() == 0);
        end
        if (!ok) expired("wait_rsp_empty");
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_strobes"}, {io_fifo_cmd_ready, io_fifo_rsp_valid,
            io_mem_cmd_en, io_mem_wr_data_en, io_mem_wr_data_end}, 5'b0);
        chk({tag, "_cmd"}, io_mem_cmd, 3'b000);
        chk({tag, "_addr"}, io_mem_addr, 27'd0);
        chk({tag, "_wdata"}, io_mem_wr_data, 128'd0);
        chk({tag, "_mask"}, io_mem_wr_data_mask, 16'hFFFF);
        chk({tag, "_rsp_data"}, io_fifo_rsp_data, 128'd0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int n0;
        int r0;
        bit ok;

        tbl[0] = '{1'b0, 27'h000001F, 6'd0, {16{8'hAA}}, 16'h00FF, 1,
                   1, 27'h0000010, 27'h0000010, 0, 0};
        tbl[1] = '{1'b1, 27'h0000100, 6'd2, 128'd0, 16'h0, 5,
                   3, 27'h0000100, 27'h0000120, 3, 2};
        tbl[2] = '{1'b1, 27'h7FFFFF5, 6'd3, 128'd0, 16'h0, 3,
                   4, 27'h7FFFFF0, 27'h0000020, 4, 3};
        tbl[3] = '{1'b0, 27'h7FFFFFF, 6'd9, {4{32'h1234_5678}}, 16'h0000, 1,
                   1, 27'h7FFFFF0, 27'h7FFFFF0, 0, 0};
        tbl[4] = '{1'b1, 27'h0000000, 6'd63, 128'd0, 16'h0, 1,
                   64, 27'h0000000, 27'h00003F0, 64, 63};
        tbl[5] = '{1'b1, 27'h0000003, 6'd0, 128'd0, 16'h0, 2,
                   1, 27'h0000000, 27'h0000000, 1, 0};

        repeat (3) @(posedge clk);
        #2;
        check_reset("rst");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            lat = tbl[i].lat;
            t_n = 0;
            r0 = n_rsp;
            send(tbl[i].typ, tbl[i].addr, tbl[i].burst, tbl[i].data,
                 tbl[i].mask);
            wait_idle(1000);
            wait_rsp_empty(100);
            chk("tbl_ncmd", t_n, tbl[i].exp_cmds);
            chk("tbl_first", t_first, tbl[i].exp_first);
            chk("tbl_last", t_last, tbl[i].exp_last);
            chk("tbl_nrsp", n_rsp - r0, tbl[i].exp_rsps);
            chk("tbl_span", t_last_cyc - t_first_cyc, tbl[i].exp_span);
        end

        p_wr = 0;
        @(posedge clk);
        #2;
        send(1'b0, 27'h0001230, 6'd0, {8{16'hBEEF}}, 16'h0F0F);
        n0 = t_n;
        repeat (3) begin
            @(negedge clk);
            chk("wr_stall_en", io_mem_cmd_en, 1'b0);
        end
        @(posedge clk);
        #2;
        p_wr = 100;
        wait_idle(50);
        chk("wr_stall_fired", t_n - n0, 1);

        lat = 3;
        p_rsp = 0;
        @(posedge clk);
        #2;
        send(1'b1, 27'h0002340, 6'd0, 128'd0, 16'h0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = io_mem_rd_data_valid;
        end
        if (!ok) expired("rd_valid");
        chk("no_bypass", io_fifo_rsp_valid, 1'b0);
        @(negedge clk);
        chk("rsp_next", {io_fifo_rsp_valid, io_fifo_rsp_data},
            {1'b1, memf(27'h0002340)});
        @(posedge clk);
        #2;
        p_rsp = 100;
        wait_idle(50);
        wait_rsp_empty(50);

        lat = 2;
        p_rsp = 0;
        @(posedge clk);
        #2;
        n0 = t_n;
        r0 = n_rsp;
        send(1'b1, 27'h0000500, 6'd7, 128'd0, 16'h0);
        repeat (20) @(negedge clk);
        #1;
        chk("credit_stall_ncmd", t_n - n0, 4);
        chk("credit_stall_valid", io_fifo_rsp_valid, 1'b1);
        @(posedge clk);
        #2;
        p_rsp = 100;
        wait_idle(200);
        wait_rsp_empty(50);
        chk("credit_total_ncmd", t_n - n0, 8);
        chk("credit_total_nrsp", n_rsp - r0, 8);

        io_mem_init_calib_complete = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n0 = t_n;
        io_fifo_cmd_valid = 1'b1;
        io_fifo_cmd_type = 1'b0;
        io_fifo_cmd_addr = 27'h0004440;
        io_fifo_cmd_wt_data = {4{32'hCAFE_F00D}};
        io_fifo_cmd_wt_mask = 16'hA5A5;
        repeat (4) begin
            @(negedge clk);
            chk("nocalib_ready", io_fifo_cmd_ready, 1'b0);
        end
        chk("nocalib_ncmd", t_n - n0, 0);
        @(posedge clk);
        #2;
        io_mem_init_calib_complete = 1'b1;
        @(negedge clk);
        chk("calib_rise_ready0", io_fifo_cmd_ready, 1'b0);
        @(negedge clk);
        chk("calib_rise_ready1", io_fifo_cmd_ready, 1'b1);
        @(posedge clk);
        #2;
        io_fifo_cmd_valid = 1'b0;
        wait_idle(50);
        chk("calib_ncmd", t_n - n0, 1);

        @(posedge clk);
        #2;
        r0 = n_rsp_any;
        mq.push_back(beat_t'{cyc + 1, {4{32'hDEAD_BEEF}}});
        repeat (5) @(negedge clk);
        #1;
        chk("idle_drop", n_rsp_any - r0, 0);

        lat = 5;
        n0 = t_n;
        send(1'b1, 27'h000ABC0, 6'd7, 128'd0, 16'h0);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = (t_n - n0 >= 2);
        end
        if (!ok) expired("mid_rst_issue");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        exp_cmd.delete();
        exp_rsp.delete();
        issued = 0;
        popped = 0;
        hold_prev = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        r0 = n_rsp_any;
        repeat (12) @(negedge clk);
        #1;
        chk("drop_after_rst", n_rsp_any - r0, 0);
        wait_idle(50);

        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #2;
            p_cmd = $urandom_range(40, 100);
            p_wr = $urandom_range(40, 100);
            p_rsp = $urandom_range(30, 100);
            lat = $urandom_range(1, 6);
            send($urandom_range(1), 27'($urandom),
                 ($urandom_range(3) == 0) ? 6'($urandom_range(63))
                                          : 6'($urandom_range(7)),
                 {$urandom, $urandom, $urandom, $urandom},
                 16'($urandom));
            wait_idle(2000);
        end
        @(posedge clk);
        #2;
        p_rsp = 100;
        wait_rsp_empty(100);
        chk("end_cmd_queue", exp_cmd.size(), 0);
        chk("end_rsp_queue", exp_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
